channel_conversion_ctrl: RTL and testbench

Per-channel sequencer for one analog channel (CSA, discriminator, SAR ADC) of the 64-channel analog core. It detects a discriminator hit or an external trigger and runs the conversion: it holds the sample switch, performs the successive-approximation search by driving the trial DAC word and the comparator strobe, and hands the result to the channel FIFO over a valid/ready handshake. It can then pulse the CSA reset. One instance sits in the digital core per channel, between `analog_core` and the channel FIFO.

---
 rtl/channel_conversion_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_channel_conversion_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/channel_conversion_ctrl.sv
// Per-channel sequencer: trigger detect, sample hold, SAR search, FIFO handshake and CSA reset.
// Every output is a flop loaded from the next-state/output logic of the FSM.
module channel_conversion_ctrl #(
  parameter int unsigned ADCBITS       = 10,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned RESET_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               reset_after_hit,
  input  logic               hit,
  input  logic               external_trigger,
  input  logic               comp,
  output logic               sample,
  output logic               strobe,
  output logic [ADCBITS-1:0] dac_word,
  output logic               csa_reset,
  output logic [ADCBITS-1:0] adc_word,
  output logic               trigger_type,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               busy,
  output logic               hit_dropped
);

  localparam int unsigned CW = 4;
  localparam int unsigned BW = (ADCBITS > 1) ? $clog2(ADCBITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONVERT,
    S_HOLD,
    S_CSA_RST
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [BW-1:0]      r_bit, w_bit_nxt;
  logic               r_phase, w_phase_nxt;
  logic [ADCBITS-1:0] r_result, w_result_nxt;
  logic [ADCBITS-1:0] w_trial, w_kept;
  logic               r_hit_s1, r_hit_s2, r_hit_s3, r_ext;
  logic               w_hit_trig, w_trig, w_accept;
  logic               w_sample_nxt, w_strobe_nxt, w_csa_reset_nxt, w_trig_type_nxt;
  logic               w_word_valid_nxt, w_busy_nxt, w_drop_nxt;
  logic [ADCBITS-1:0] w_dac_nxt, w_adc_word_nxt;

  // hit crosses clock domains; the external trigger gets one flop so it lands a cycle ahead of hit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_s1 <= 1'b0;
      r_hit_s2 <= 1'b0;
      r_hit_s3 <= 1'b0;
      r_ext    <= 1'b0;
    end else begin
      r_hit_s1 <= hit;
      r_hit_s2 <= r_hit_s1;
      r_hit_s3 <= r_hit_s2;
      r_ext    <= external_trigger;
    end
  end

  assign w_hit_trig = r_hit_s2 & ~r_hit_s3;
  assign w_trig     = w_hit_trig | r_ext;
  assign w_trial    = r_result | (ADCBITS'(1) << r_bit);
  assign w_kept     = comp ? w_trial : r_result;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_bit_nxt        = r_bit;
    w_phase_nxt      = r_phase;
    w_result_nxt     = r_result;
    w_sample_nxt     = 1'b0;
    w_strobe_nxt     = 1'b0;
    w_dac_nxt        = '0;
    w_csa_reset_nxt  = 1'b0;
    w_adc_word_nxt   = adc_word;
    w_trig_type_nxt  = trigger_type;
    w_word_valid_nxt = 1'b0;
    w_drop_nxt       = 1'b0;
    w_accept         = 1'b0;
    w_busy_nxt       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_accept = w_trig;
      end
      S_SAMPLE: begin
        w_drop_nxt = w_trig;
        if (r_cnt == '0) begin
          w_state_nxt = S_CONVERT;
          w_bit_nxt   = BW'(ADCBITS - 1);
          w_phase_nxt = 1'b0;
          w_dac_nxt   = ADCBITS'(1) << (ADCBITS - 1);
        end else begin
          w_cnt_nxt    = r_cnt - CW'(1);
          w_sample_nxt = 1'b1;
        end
      end
      S_CONVERT: begin
        w_drop_nxt = w_trig;
        if (!r_phase) begin
          w_phase_nxt  = 1'b1;
          w_strobe_nxt = 1'b1;
          w_dac_nxt    = w_trial;
        end else begin
          w_result_nxt = w_kept;
          if (r_bit == '0) begin
            w_state_nxt      = S_HOLD;
            w_adc_word_nxt   = w_kept;
            w_word_valid_nxt = 1'b1;
          end else begin
            w_bit_nxt   = r_bit - BW'(1);
            w_phase_nxt = 1'b0;
            w_dac_nxt   = w_kept | (ADCBITS'(1) << (r_bit - BW'(1)));
          end
        end
      end
      S_HOLD: begin
        if (word_ready) begin
          if (reset_after_hit) begin
            w_state_nxt     = S_CSA_RST;
            w_cnt_nxt       = CW'(RESET_CYCLES - 1);
            w_csa_reset_nxt = 1'b1;
            w_drop_nxt      = w_trig;
          end else begin
            w_state_nxt = S_IDLE;
            w_accept    = w_trig;
          end
        end else begin
          w_word_valid_nxt = 1'b1;
          w_drop_nxt       = w_trig;
        end
      end
      S_CSA_RST: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_accept    = w_trig;
        end else begin
          w_cnt_nxt       = r_cnt - CW'(1);
          w_csa_reset_nxt = 1'b1;
          w_drop_nxt      = w_trig;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // a trigger on the last cycle of a word or reset pulse starts the next conversion back-to-back
    if (w_accept) begin
      w_state_nxt     = S_SAMPLE;
      w_cnt_nxt       = CW'(SAMPLE_CYCLES - 1);
      w_result_nxt    = '0;
      w_sample_nxt    = 1'b1;
      w_csa_reset_nxt = 1'b0;
      w_trig_type_nxt = ~w_hit_trig;
    end

    if (!enable) begin
      w_state_nxt      = S_IDLE;
      w_sample_nxt     = 1'b0;
      w_strobe_nxt     = 1'b0;
      w_dac_nxt        = '0;
      w_csa_reset_nxt  = 1'b1;
      w_word_valid_nxt = 1'b0;
      w_drop_nxt       = 1'b0;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_phase      <= 1'b0;
      r_result     <= '0;
      sample       <= 1'b0;
      strobe       <= 1'b0;
      dac_word     <= '0;
      csa_reset    <= 1'b1;
      adc_word     <= '0;
      trigger_type <= 1'b0;
      word_valid   <= 1'b0;
      busy         <= 1'b0;
      hit_dropped  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit        <= w_bit_nxt;
      r_phase      <= w_phase_nxt;
      r_result     <= w_result_nxt;
      sample       <= w_sample_nxt;
      strobe       <= w_strobe_nxt;
      dac_word     <= w_dac_nxt;
      csa_reset    <= w_csa_reset_nxt;
      adc_word     <= w_adc_word_nxt;
      trigger_type <= w_trig_type_nxt;
      word_valid   <= w_word_valid_nxt;
      busy         <= w_busy_nxt;
      hit_dropped  <= w_drop_nxt;
    end
  end

endmodule

// File: tb/tb_channel_conversion_ctrl.sv
// Directed bench for channel_conversion_ctrl: SAR result, latency, handshake, CSA reset, enable and reset_n.
`timescale 1ns/1ps
module tb_channel_conversion_ctrl;

  logic       clk, reset_n, enable, reset_after_hit, hit, external_trigger, comp;
  logic       sample, strobe, csa_reset, trigger_type, word_valid, word_ready, busy, hit_dropped;
  logic [9:0] dac_word, adc_word;

  logic [9:0] vin;
  logic [1:0] comp_mode;
  int         n_checks, n_fail;
  int         lat, n_strobe, n_samp, samp_first, n_drop, n_trial;
  logic [9:0] trials [10];

  channel_conversion_ctrl #(.ADCBITS(10), .SAMPLE_CYCLES(2), .RESET_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .reset_after_hit(reset_after_hit),
    .hit(hit), .external_trigger(external_trigger), .comp(comp),
    .sample(sample), .strobe(strobe), .dac_word(dac_word), .csa_reset(csa_reset),
    .adc_word(adc_word), .trigger_type(trigger_type), .word_valid(word_valid),
    .word_ready(word_ready), .busy(busy), .hit_dropped(hit_dropped)
  );

  // analog model: ideal comparator, or stuck high/low
  assign comp = (comp_mode == 2'd1) ? 1'b1 : (comp_mode == 2'd2) ? 1'b0 : (vin >= dac_word);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // offset e counts edges since the trigger input was first sampled; stops at word_valid or budget
  task automatic run_until_valid(input int budget);
    lat = -1; n_strobe = 0; n_samp = 0; samp_first = -1; n_drop = 0; n_trial = 0;
    for (int e = 0; e < budget; e++) begin
      @(negedge clk);
      external_trigger = 1'b0;
      if (e == 3) hit = 1'b0;
      if (hit_dropped) n_drop++;
      if (sample) begin
        if (samp_first < 0) samp_first = e;
        n_samp++;
      end
      if (strobe) begin
        if (n_trial < 10) trials[n_trial] = dac_word;
        n_trial++;
        n_strobe++;
      end
      if (word_valid) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic count_csa(input int n, output int cnt, output int first);
    cnt = 0; first = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (csa_reset) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, first, bad, vcnt;
    n_checks = 0; n_fail = 0;
    reset_n = 1'b0; enable = 1'b0; reset_after_hit = 1'b0; hit = 1'b0;
    external_trigger = 1'b0; word_ready = 1'b1; vin = 10'h2A5; comp_mode = 2'd0;

    idle(2);
    check("rst_csa_reset", 32'(csa_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_dac", 32'(dac_word), 32'd0);
    reset_n = 1'b1; enable = 1'b1;
    idle(3);
    check("idle_csa_reset", 32'(csa_reset), 32'd0);

    // nominal hit conversion of 0x2A5
    hit = 1'b1;
    run_until_valid(60);
    check("hit_latency", 32'(lat), 32'd24);
    check("hit_adc_word", 32'(adc_word), 32'h2A5);
    check("hit_trig_type", 32'(trigger_type), 32'd0);
    check("hit_strobes", 32'(n_strobe), 32'd10);
    check("hit_sample_first", 32'(samp_first), 32'd2);
    check("hit_sample_len", 32'(n_samp), 32'd2);
    check("trial0", 32'(trials[0]), 32'h200);
    check("trial1", 32'(trials[1]), 32'h300);
    check("trial2", 32'(trials[2]), 32'h280);
    check("trial3", 32'(trials[3]), 32'h2C0);
    check("trial9", 32'(trials[9]), 32'h2A5);
    check("hold_dac_zero", 32'(dac_word), 32'd0);
    count_csa(10, cnt, first);
    check("no_csa_pulse", 32'(cnt), 32'd0);
    check("after_busy", 32'(busy), 32'd0);
    check("after_valid", 32'(word_valid), 32'd0);

    // stuck comparator extremes
    comp_mode = 2'd1; hit = 1'b1;
    run_until_valid(60);
    check("all_ones", 32'(adc_word), 32'h3FF);
    idle(5);
    comp_mode = 2'd2; hit = 1'b1;
    run_until_valid(60);
    check("all_zeros_lat", 32'(lat), 32'd24);
    check("all_zeros", 32'(adc_word), 32'h000);
    idle(5);

    // external trigger: one cycle shorter latency
    comp_mode = 2'd0; vin = 10'h155; external_trigger = 1'b1;
    run_until_valid(60);
    check("ext_latency", 32'(lat), 32'd23);
    check("ext_trig_type", 32'(trigger_type), 32'd1);
    check("ext_adc_word", 32'(adc_word), 32'h155);
    idle(5);

    // backpressure with a dropped hit during HOLD
    vin = 10'h2A5; word_ready = 1'b0; hit = 1'b1;
    run_until_valid(60);
    check("bp_latency", 32'(lat), 32'd24);
    bad = 0; n_drop = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 10) hit = 1'b1;
      if (i == 14) hit = 1'b0;
      if (!word_valid || adc_word != 10'h2A5) bad++;
      if (hit_dropped) n_drop++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    check("bp_drop_pulses", 32'(n_drop), 32'd1);
    word_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake", 32'(word_valid), 32'd0);
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (word_valid) vcnt++;
    end
    check("bp_single_word", 32'(vcnt), 32'd0);
    check("bp_not_busy", 32'(busy), 32'd0);

    // CSA reset pulse after handshake
    reset_after_hit = 1'b1; vin = 10'h0AA; hit = 1'b1;
    run_until_valid(60);
    check("rah_adc_word", 32'(adc_word), 32'h0AA);
    count_csa(4, cnt, first);
    check("rah_csa_first", 32'(first), 32'd0);
    check("rah_csa_len", 32'(cnt), 32'd4);
    @(negedge clk);
    check("rah_csa_low", 32'(csa_reset), 32'd0);
    check("rah_busy_low", 32'(busy), 32'd0);
    reset_after_hit = 1'b0;
    idle(3);

    // enable dropped during bit 5
    vin = 10'h2A5; hit = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      @(negedge clk);
      if (e == 3) hit = 1'b0;
    end
    check("en_bit5_trial", 32'(dac_word), 32'h2A0);
    enable = 1'b0;
    @(negedge clk);
    check("en_busy", 32'(busy), 32'd0);
    check("en_csa_reset", 32'(csa_reset), 32'd1);
    check("en_dac", 32'(dac_word), 32'd0);
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (word_valid) vcnt++;
    end
    check("en_no_valid", 32'(vcnt), 32'd0);
    enable = 1'b1;
    idle(3);
    vin = 10'h0F0; hit = 1'b1;
    run_until_valid(60);
    check("reen_latency", 32'(lat), 32'd24);
    check("reen_adc_word", 32'(adc_word), 32'h0F0);
    idle(5);

    // async reset mid-SAMPLE
    vin = 10'h1C3; hit = 1'b1;
    for (int e = 0; e <= 2; e++) @(negedge clk);
    check("mid_sample_high", 32'(sample), 32'd1);
    hit = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_sample", 32'(sample), 32'd0);
    check("arst_csa_reset", 32'(csa_reset), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    hit = 1'b1;
    run_until_valid(60);
    check("post_rst_latency", 32'(lat), 32'd24);
    check("post_rst_adc_word", 32'(adc_word), 32'h1C3);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
